// File: rtl/uart_wb_arbiter.sv
// uart_wb_arbiter: shares one Wishbone classic slave (the uart_tx character
// port) between NUM_REQ Wishbone classic masters. Grants are round-robin and
// stay locked for a master's whole cycle. A per-cycle watchdog aborts slave
// transfers that never ack and reports them through that master's err line.
module uart_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        m_cyc_i,
  input  logic [NUM_REQ-1:0]        m_stb_i,
  input  logic [NUM_REQ-1:0]        m_we_i,
  input  logic [NUM_REQ*DATA_W-1:0] m_dat_i,
  output logic [NUM_REQ-1:0]        m_ack_o,
  output logic [NUM_REQ-1:0]        m_err_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [DATA_W-1:0]         s_dat_o,
  input  logic                      s_ack_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // The counter only has to reach TIMEOUT-1 before the abort fires.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   grant_idx, grant_idx_next;
  logic [IDX_W-1:0]   last, last_next;
  logic [CNT_W-1:0]   wd_cnt, wd_cnt_next;
  logic [NUM_REQ-1:0] err_q, err_next;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  int                 cand;

  // Round-robin pick: first requester scanning upward from last+1 with wrap.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    cand       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_valid && m_cyc_i[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state, watchdog and output decode from the registered state/grant.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned; that is what keeps this block free of inferred latches.
    state_next     = state;
    grant_idx_next = grant_idx;
    last_next      = last;
    wd_cnt_next    = '0;
    err_next       = '0;
    grant_o        = '0;
    busy_o         = 1'b0;
    s_cyc_o        = 1'b0;
    s_stb_o        = 1'b0;
    s_we_o         = 1'b0;
    s_dat_o        = '0;
    m_ack_o        = '0;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next     = GRANT;
          grant_idx_next = pick_idx;
        end
      end

      GRANT: begin
        grant_o[grant_idx] = 1'b1;
        busy_o             = 1'b1;
        s_cyc_o            = m_cyc_i[grant_idx];
        s_stb_o            = m_stb_i[grant_idx];
        s_we_o             = m_we_i[grant_idx];
        s_dat_o            = m_dat_i[grant_idx*DATA_W +: DATA_W];
        m_ack_o[grant_idx] = s_ack_i;
        if (!m_cyc_i[grant_idx]) begin
          state_next = IDLE;
          last_next  = grant_idx;
        end else if (WD_EN && s_stb_o && !s_ack_i) begin
          // An ack in the final waiting cycle takes the else-branch above
          // this one never runs, so a late ack always beats the abort.
          if (wd_cnt == WD_LAST) begin
            state_next          = ABORT;
            err_next[grant_idx] = 1'b1;
          end else begin
            wd_cnt_next = wd_cnt + 1'b1;
          end
        end
      end

      ABORT: begin
        // Slave side stays quiet and its ack is ignored until the master lets go.
        grant_o[grant_idx] = 1'b1;
        busy_o             = 1'b1;
        if (!m_cyc_i[grant_idx]) begin
          state_next = IDLE;
          last_next  = grant_idx;
        end
      end

      default: state_next = IDLE;
    endcase

    m_err_o = err_q;
  end

  // State, grant, priority pointer, watchdog and error pulse registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (rst_i) begin
      state     <= IDLE;
      grant_idx <= '0;
      last      <= IDX_W'(NUM_REQ - 1);
      wd_cnt    <= '0;
      err_q     <= '0;
    end else begin
      state     <= state_next;
      grant_idx <= grant_idx_next;
      last      <= last_next;
      wd_cnt    <= wd_cnt_next;
      err_q     <= err_next;
    end
  end

endmodule
